// File: rtl/twiddle_idx_seq.sv
// rtl/twiddle_idx_seq.sv - row-major N x N twiddle index sweep with quadrant folding
//
// Walks every (row, col) pair of an N x N transform. For each row the block
// drives row_sel to an external index-product array, captures its N products
// (row*i mod N) in one LOAD cycle, then streams one descriptor per column
// under a valid/ready handshake. Each descriptor carries the raw index k and
// its quarter-table fold (residue plus swap / sign flags).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin a full sweep (ignored while busy)
//   row_sel             row multiplicand for the upstream product array
//   idx_in[N]           products row_sel*i mod N from that array
//   out_valid/out_ready descriptor handshake
//   out_row, out_col    coordinates of the presented element
//   out_idx, out_res    raw index k and quarter-table residue
//   out_swap, out_cos_neg, out_sin_neg  quadrant folding flags
//   busy, done          sweep in progress; one-cycle completion pulse

module twiddle_idx_seq #(
    parameter int N     = 8,
    parameter int WIDTH = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] row_sel,
    input  logic [WIDTH-1:0] idx_in [N-1:0],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_row,
    output logic [WIDTH-1:0] out_col,
    output logic [WIDTH-1:0] out_idx,
    output logic [WIDTH-3:0] out_res,
    output logic             out_swap,
    output logic             out_cos_neg,
    output logic             out_sin_neg,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] row;
    logic [WIDTH-1:0] col;
    logic [WIDTH-1:0] rowbuf [N-1:0];
    logic             xfer;
    logic             last_col;
    logic             last_row;
    logic [1:0]       quad;

    assign xfer     = out_valid && out_ready;
    assign last_col = (col == LAST);
    assign last_row = (row == LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nx = S_STREAM;
            end
            S_STREAM: begin
                if (xfer && last_col) begin
                    state_nx = last_row ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Row / column counters and row buffer.
    // The buffer is written only in LOAD, so the upstream array is free to
    // change while a row streams out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
            for (int i = 0; i < N; i++) begin
                rowbuf[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        row <= '0;
                        col <= '0;
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < N; i++) begin
                        rowbuf[i] <= idx_in[i];
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        if (!last_col) begin
                            col <= col + WIDTH'(1);
                        end else if (!last_row) begin
                            row <= row + WIDTH'(1);
                            col <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state == S_STREAM);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

    // Payload is a pure function of registered row/col/buffer, so it holds
    // steady through any number of stalled cycles.
    assign row_sel = row;
    assign out_row = row;
    assign out_col = col;
    assign out_idx = rowbuf[col];

    // Quadrant fold: the top two index bits select the quadrant, the rest
    // address a quarter-wave table. Odd quadrants swap sin/cos.
    assign quad        = out_idx[WIDTH-1:WIDTH-2];
    assign out_res     = out_idx[WIDTH-3:0];
    assign out_swap    = quad[0];
    assign out_cos_neg = (quad == 2'd1) || (quad == 2'd2);
    assign out_sin_neg = quad[1];

endmodule

// File: tb/tb_twiddle_idx_seq.sv
// tb/tb_twiddle_idx_seq.sv - self-checking bench for twiddle_idx_seq
module tb_twiddle_idx_seq;

    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef struct packed {
        logic [W-1:0] row;
        logic [W-1:0] col;
        logic [W-1:0] idx;
        logic [W-3:0] res;
        logic         swap;
        logic         cn;
        logic         sn;
    } desc_t;

    typedef struct {
        int row;
        int col;
        int idx;
        int res;
        int swap;
        int cn;
        int sn;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         out_ready = 1'b0;
    logic         corrupt = 1'b0;
    logic [W-1:0] row_sel;
    logic [W-1:0] idx_in [N-1:0];
    logic         out_valid;
    logic [W-1:0] out_row;
    logic [W-1:0] out_col;
    logic [W-1:0] out_idx;
    logic [W-3:0] out_res;
    logic         out_swap;
    logic         out_cos_neg;
    logic         out_sin_neg;
    logic         busy;
    logic         done;

    int    checks = 0;
    int    errors = 0;
    desc_t sbq [$];
    desc_t cap [N][N];
    vec_t  tbl [$];
    int    xfers = 0;
    desc_t prev;
    logic  prev_stall = 1'b0;

    always #5 clk = ~clk;

    twiddle_idx_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .row_sel    (row_sel),
        .idx_in     (idx_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_idx    (out_idx),
        .out_res    (out_res),
        .out_swap   (out_swap),
        .out_cos_neg(out_cos_neg),
        .out_sin_neg(out_sin_neg),
        .busy       (busy),
        .done       (done)
    );

    // Upstream product array; when corrupt is set, garbage is presented
    // whenever the DUT is streaming (it must be ignored then).
    always_comb begin
        for (int i = 0; i < N; i++) begin
            idx_in[i] = W'((int'(row_sel) * i) % N) ^ {W{corrupt && out_valid}};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic desc_t model(input int r, input int c);
        desc_t d;
        int k;
        int quad;
        k      = (r * c) % N;
        quad   = k / (N / 4);
        d.row  = W'(r);
        d.col  = W'(c);
        d.idx  = W'(k);
        d.res  = (W-2)'(k % (N / 4));
        d.swap = (quad % 2) == 1;
        d.cn   = (quad == 1) || (quad == 2);
        d.sn   = (quad >= 2);
        return d;
    endfunction

    task automatic push_sweep();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                sbq.push_back(model(r, c));
    endtask

    // Transfer monitor / scoreboard and stall-stability checker.
    always @(negedge clk) begin
        desc_t got;
        got = {out_row, out_col, out_idx, out_res, out_swap, out_cos_neg, out_sin_neg};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_hold", 32'(out_valid), 32'd1);
                chk("stall_payload_hold", 32'(got), 32'(prev));
            end
            prev_stall = out_valid && !out_ready;
            prev = got;
            if (out_valid && out_ready) begin
                xfers++;
                cap[got.row][got.col] = got;
                if (sbq.size() == 0) begin
                    chk("xfer_unexpected", 32'(got), 32'h1fff_ffff);
                end else begin
                    chk("xfer_payload", 32'(got), 32'(sbq.pop_front()));
                end
            end
        end
    end

    // One sweep: start pulse, optional random stalls and start spam while busy.
    task automatic run_sweep(input bit rnd, output int first_v, output int done_at,
                             output int done_cnt);
        int cyc;
        cyc      = 0;
        first_v  = -1;
        done_at  = -1;
        done_cnt = 0;
        xfers    = 0;
        push_sweep();
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        while (cyc < 3000 && !(done_cnt > 0 && !busy)) begin
            if (out_valid && first_v < 0) first_v = cyc + 1;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc + 1;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (rnd) begin
                out_ready = ($urandom % 4) != 0;
                start = busy && (($urandom % 6) == 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("sweep_timeout", 32'(cyc >= 3000), 32'd0);
        chk("sweep_xfer_count", 32'(xfers), 32'(N * N));
        chk("sweep_sb_empty", 32'(sbq.size()), 32'd0);
        chk("done_one_cycle", 32'(done_cnt), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_row_sel"}, 32'(row_sel), 32'd0);
        chk({tag, "_payload"},
            32'({out_row, out_col, out_idx, out_res, out_swap, out_cos_neg, out_sin_neg}), 32'd0);
    endtask

    initial begin
        int first_v;
        int done_at;
        int done_cnt;
        int waited;

        // Hand-derived fold vectors: row 3 sequence, plus k=5 and k=6 on row 1.
        tbl.push_back('{3, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{3, 1, 3, 1, 1, 1, 0});
        tbl.push_back('{3, 2, 6, 0, 1, 0, 1});
        tbl.push_back('{3, 3, 1, 1, 0, 0, 0});
        tbl.push_back('{3, 4, 4, 0, 0, 1, 1});
        tbl.push_back('{3, 5, 7, 1, 1, 0, 1});
        tbl.push_back('{3, 6, 2, 0, 1, 1, 0});
        tbl.push_back('{3, 7, 5, 1, 0, 1, 1});
        tbl.push_back('{1, 5, 5, 1, 0, 1, 1});
        tbl.push_back('{1, 6, 6, 0, 1, 0, 1});
        tbl.push_back('{7, 7, 1, 1, 0, 0, 0});

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // Full-throughput sweep: latency and ordering.
        run_sweep(1'b0, first_v, done_at, done_cnt);
        chk("first_valid_latency", 32'(first_v), 32'd2);
        chk("done_latency", 32'(done_at), 32'(N * (N + 1) + 1));

        for (int i = 0; i < tbl.size(); i++) begin
            desc_t d;
            d = cap[tbl[i].row][tbl[i].col];
            chk($sformatf("tbl%0d_idx", i), 32'(d.idx), 32'(tbl[i].idx));
            chk($sformatf("tbl%0d_res", i), 32'(d.res), 32'(tbl[i].res));
            chk($sformatf("tbl%0d_flags", i), 32'({d.swap, d.cn, d.sn}),
                32'({tbl[i].swap[0], tbl[i].cn[0], tbl[i].sn[0]}));
        end

        // Random stalls, start spam while busy, upstream corrupted while streaming.
        corrupt = 1'b1;
        run_sweep(1'b1, first_v, done_at, done_cnt);
        corrupt = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_spam", 32'(busy), 32'd0);

        // Reset in the middle of row 4.
        push_sweep();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waited = 0;
        while (!(out_valid && out_row == W'(4)) && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("row4_reached", 32'(waited < 500), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_reset_vals("midreset");
        sbq.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("no_resume_busy", 32'(busy), 32'd0);
        chk("no_resume_valid", 32'(out_valid), 32'd0);

        run_sweep(1'b0, first_v, done_at, done_cnt);
        chk("restart_first_latency", 32'(first_v), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
